// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and width helpers for the direct-mapped cache
//               controller (FSM state encoding, index/tag width calculation).
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

  // Controller FSM states, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EVICT     = 2'd1,
    ST_FILL_REQ  = 2'd2,
    ST_FILL_WAIT = 2'd3
  } state_t;

  // Width of the optional hit/miss statistics counters.
  localparam int STATS_W = 16;

  // Index width for a given line count (at least one bit).
  function automatic int calc_idx_w(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

  // Tag width: the address bits left over once the index is removed.
  function automatic int calc_tag_w(input int addr_w, input int lines);
    return addr_w - calc_idx_w(lines);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_line_store.sv
`default_nettype none
// ============================================================================
// Module      : cache_line_store
// Description : Tag / valid / dirty / data storage for the direct-mapped
//               cache. One combinational read port, one synchronous write
//               port. Valid and dirty bits are cleared synchronously by rst;
//               tag and data contents are don't-care while a line is invalid.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               rd_idx -> rd_*        - combinational lookup of one line
//               wr_en, wr_idx, wr_*   - whole-line write on rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module cache_line_store
  import cache_pkg::*;
#(
  parameter  int ADDR_W = 8,
  parameter  int DATA_W = 8,
  parameter  int LINES  = 4,
  localparam int IDX_W  = calc_idx_w(LINES),
  localparam int TAG_W  = calc_tag_w(ADDR_W, LINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_valid,
  input  logic              wr_dirty,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  logic [LINES-1:0]  w_valid;
  logic [LINES-1:0]  w_dirty;
  logic [TAG_W-1:0]  w_tag  [LINES];
  logic [DATA_W-1:0] w_data [LINES];

  for (genvar g = 0; g < LINES; g++) begin : g_line
    logic              r_valid;
    logic              r_dirty;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_data;
    logic              w_sel;

    assign w_sel = wr_en && (wr_idx == IDX_W'(g));

    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_dirty <= 1'b0;
      end else if (w_sel) begin
        r_valid <= wr_valid;
        r_dirty <= wr_dirty;
      end
    end

    // Payload needs no reset: it is only observed behind a set valid bit.
    always_ff @(posedge clk) begin
      if (w_sel) begin
        r_tag  <= wr_tag;
        r_data <= wr_data;
      end
    end

    assign w_valid[g] = r_valid;
    assign w_dirty[g] = r_dirty;
    assign w_tag[g]   = r_tag;
    assign w_data[g]  = r_data;
  end

  assign rd_valid = w_valid[rd_idx];
  assign rd_dirty = w_dirty[rd_idx];
  assign rd_tag   = w_tag[rd_idx];
  assign rd_data  = w_data[rd_idx];

endmodule
`default_nettype wire

// File: rtl/cache_ctrl_dm.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_dm
// Description : Direct-mapped, write-back, write-allocate cache controller.
//               Single-word lines, one outstanding CPU request. Hits answer
//               the cycle after acceptance; misses evict a dirty victim and/or
//               refill through a valid/ready backing-memory handshake.
// Ports       : clk, rst                          - clock, sync active-high reset
//               req_valid/ready/we/addr/wdata     - CPU request channel
//               resp_valid/hit/rdata              - CPU response (1-cycle pulse)
//               mem_req_valid/ready/we/addr/wdata - backing memory request
//               mem_rvalid/rdata                  - backing memory refill data
//               hit_cnt, miss_cnt                 - only with CACHE_STATS_EN
// Config      : define CACHE_STATS_EN to add saturating hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl_dm
  import cache_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LINES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [STATS_W-1:0] hit_cnt,
  output logic [STATS_W-1:0] miss_cnt
`endif
);

  localparam int IDX_W = calc_idx_w(LINES);
  localparam int TAG_W = calc_tag_w(ADDR_W, LINES);

  state_t r_state;
  state_t w_next_state;

  // Captured request
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  // Registered response
  logic              r_resp_valid;
  logic              r_resp_hit;
  logic [DATA_W-1:0] r_resp_rdata;

  // Store interface
  logic [IDX_W-1:0]  w_rd_idx;
  logic              w_rd_valid;
  logic              w_rd_dirty;
  logic [TAG_W-1:0]  w_rd_tag;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_wr_en;
  logic              w_wr_dirty;
  logic [TAG_W-1:0]  w_wr_tag;
  logic [DATA_W-1:0] w_wr_data;

  logic              w_accept;
  logic              w_hit;
  logic              w_resp_fire;
  logic              w_resp_hit;
  logic [DATA_W-1:0] w_resp_data;

  logic [IDX_W-1:0]  w_req_idx;
  logic [TAG_W-1:0]  w_req_tag;
  logic [IDX_W-1:0]  w_cap_idx;
  logic [TAG_W-1:0]  w_cap_tag;

  assign w_req_idx = req_addr[IDX_W-1:0];
  assign w_req_tag = req_addr[ADDR_W-1:IDX_W];
  assign w_cap_idx = r_addr[IDX_W-1:0];
  assign w_cap_tag = r_addr[ADDR_W-1:IDX_W];

  // Lookups in IDLE use the live request; every other state works on the
  // captured line, which also keeps eviction data stable during a stall.
  assign w_rd_idx = (r_state == ST_IDLE) ? w_req_idx : w_cap_idx;
  assign w_hit    = w_rd_valid && (w_rd_tag == w_req_tag);

  // A miss keeps the CPU channel closed through its own response cycle, so
  // the cycle carrying a miss response is never an accept cycle.
  assign req_ready = (r_state == ST_IDLE) && !(r_resp_valid && !r_resp_hit);
  assign w_accept  = req_valid && req_ready;

  cache_line_store #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LINES  (LINES)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (w_rd_idx),
    .rd_valid (w_rd_valid),
    .rd_dirty (w_rd_dirty),
    .rd_tag   (w_rd_tag),
    .rd_data  (w_rd_data),
    .wr_en    (w_wr_en),
    .wr_idx   (w_rd_idx),
    .wr_valid (1'b1),
    .wr_dirty (w_wr_dirty),
    .wr_tag   (w_wr_tag),
    .wr_data  (w_wr_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_state      <= w_next_state;
      r_resp_valid <= w_resp_fire;
      r_resp_hit   <= w_resp_fire && w_resp_hit;
      if (w_resp_fire) begin
        r_resp_rdata <= w_resp_data;
      end
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_wr_en       = 1'b0;
    w_wr_dirty    = 1'b0;
    w_wr_tag      = w_cap_tag;
    w_wr_data     = r_wdata;
    w_resp_fire   = 1'b0;
    w_resp_hit    = 1'b0;
    w_resp_data   = '0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_hit) begin
            w_resp_fire = 1'b1;
            w_resp_hit  = 1'b1;
            w_resp_data = req_we ? req_wdata : w_rd_data;
            if (req_we) begin
              w_wr_en    = 1'b1;
              w_wr_dirty = 1'b1;
              w_wr_tag   = w_req_tag;
              w_wr_data  = req_wdata;
            end
          end else if (w_rd_valid && w_rd_dirty) begin
            w_next_state = ST_EVICT;
          end else if (req_we) begin
            // Clean-victim write miss: allocate without touching memory.
            w_wr_en     = 1'b1;
            w_wr_dirty  = 1'b1;
            w_wr_tag    = w_req_tag;
            w_wr_data   = req_wdata;
            w_resp_fire = 1'b1;
            w_resp_data = req_wdata;
          end else begin
            w_next_state = ST_FILL_REQ;
          end
        end
      end

      ST_EVICT: begin
        mem_req_valid = 1'b1;
        mem_we        = 1'b1;
        mem_addr      = {w_rd_tag, w_cap_idx};
        mem_wdata     = w_rd_data;
        if (mem_req_ready) begin
          if (r_we) begin
            w_wr_en      = 1'b1;
            w_wr_dirty   = 1'b1;
            w_resp_fire  = 1'b1;
            w_resp_data  = r_wdata;
            w_next_state = ST_IDLE;
          end else begin
            w_next_state = ST_FILL_REQ;
          end
        end
      end

      ST_FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_addr      = r_addr;
        if (mem_req_ready) begin
          w_next_state = ST_FILL_WAIT;
        end
      end

      ST_FILL_WAIT: begin
        if (mem_rvalid) begin
          w_wr_en      = 1'b1;
          w_wr_data    = mem_rdata;
          w_resp_fire  = 1'b1;
          w_resp_data  = mem_rdata;
          w_next_state = ST_IDLE;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign resp_valid = r_resp_valid;
  assign resp_hit   = r_resp_hit;
  assign resp_rdata = r_resp_rdata;

`ifdef CACHE_STATS_EN
  // Counters advance on the same edge that registers the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (w_resp_fire) begin
      if (w_resp_hit) begin
        if (hit_cnt != '1) begin
          hit_cnt <= hit_cnt + STATS_W'(1);
        end
      end else begin
        if (miss_cnt != '1) begin
          miss_cnt <= miss_cnt + STATS_W'(1);
        end
      end
    end
  end
`else
  // Statistics disabled: no counter state is built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_dm.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_ctrl_dm
// Description : Self-checking bench for cache_ctrl_dm (ADDR_W=8, DATA_W=8,
//               LINES=4). Backing memory model with 2-cycle read latency;
//               expected responses and memory transactions are queued when
//               stimulus is driven and checked when the DUT produces them.
//               Counter checks are compiled only with CACHE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl_dm;

  typedef struct packed {
    logic       hit;
    logic [7:0] data;
  } resp_t;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } memop_t;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic       resp_hit;
  logic [7:0] resp_rdata;
  logic       mem_req_valid;
  logic       mem_req_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_rvalid;
  logic [7:0] mem_rdata;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  resp_t  exp_resp[$];
  memop_t exp_mem[$];
  logic [7:0] mem_arr [256];

  cache_ctrl_dm #(
    .ADDR_W (8),
    .DATA_W (8),
    .LINES  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_hit      (resp_hit),
    .resp_rdata    (resp_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Response scoreboard
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        n_assert++;
        if (exp_resp.size() == 0) begin
          n_fail++;
          $display("FAIL resp_unexpected: got hit=%0b data=%02h, expected no response", resp_hit, resp_rdata);
        end else begin
          e = exp_resp.pop_front();
          if ({resp_hit, resp_rdata} !== {e.hit, e.data}) begin
            n_fail++;
            $display("FAIL resp: got hit=%0b data=%02h, expected hit=%0b data=%02h", resp_hit, resp_rdata, e.hit, e.data);
          end
        end
      end
    end
  end

  // Backing memory: handshake observed mid-cycle (it completes at the next
  // rising edge), read data returned with rvalid for the cycle that is
  // sampled two edges after acceptance.
  initial begin
    memop_t e;
    logic [7:0] a;
    mem_rvalid = 1'b0;
    mem_rdata  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
        n_assert++;
        if (exp_mem.size() == 0) begin
          n_fail++;
          $display("FAIL mem_unexpected: got we=%0b addr=%02h wdata=%02h, expected no memory request", mem_we, mem_addr, mem_wdata);
        end else begin
          e = exp_mem.pop_front();
          if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
            n_fail++;
            $display("FAIL mem_req: got we=%0b addr=%02h wdata=%02h, expected we=%0b addr=%02h wdata=%02h", mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
          end
        end
        a = mem_addr;
        if (mem_we === 1'b1) begin
          mem_arr[a] = mem_wdata;
        end else begin
          @(posedge clk);
          @(posedge clk);
          #1;
          mem_rvalid = 1'b1;
          mem_rdata  = mem_arr[a];
          @(posedge clk);
          #1;
          mem_rvalid = 1'b0;
          mem_rdata  = 8'h00;
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wd);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    while (req_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    n_assert++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready: req_ready=%0b after %0d cycles, expected 1", req_ready, n);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (resp_valid !== 1'b1 && n < 60);
    n_assert++;
    if (resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: resp_valid=%0b after %0d cycles, expected 1", name, resp_valid, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_assert++;
    if ({req_ready, resp_valid, resp_hit, resp_rdata} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_resp: got ready=%0b valid=%0b hit=%0b rdata=%02h, expected 1 0 0 00", req_ready, resp_valid, resp_hit, resp_rdata);
    end
    n_assert++;
    if ({mem_req_valid, mem_we, mem_addr, mem_wdata} !== {1'b0, 1'b0, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_mem: got valid=%0b we=%0b addr=%02h wdata=%02h, expected 0 0 00 00", mem_req_valid, mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_assert++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %0b, expected 1", req_ready);
    end
  endtask

  task automatic test_read_miss();
    exp_mem.push_back('{we: 1'b0, addr: 8'h05, wdata: 8'h00});
    exp_resp.push_back('{hit: 1'b0, data: 8'hA5});
    issue(1'b0, 8'h05, 8'h00);
    wait_resp("read_miss");
    n_assert++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL read_miss_ready: got %0b in miss response cycle, expected 0", req_ready);
    end
    exp_resp.push_back('{hit: 1'b1, data: 8'hA5});
    issue(1'b0, 8'h05, 8'h00);
    @(negedge clk);
    n_assert++;
    if (resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL read_hit_latency: resp_valid=%0b one cycle after accept, expected 1", resp_valid);
    end
  endtask

  task automatic test_write_clean_miss();
    exp_resp.push_back('{hit: 1'b0, data: 8'h3C});
    issue(1'b1, 8'h09, 8'h3C);
    @(negedge clk);
    n_assert++;
    if ({resp_valid, req_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL wmiss_cycle: got valid=%0b ready=%0b, expected valid=1 ready=0", resp_valid, req_ready);
    end
    @(negedge clk);
    n_assert++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wmiss_ready_back: got %0b, expected 1", req_ready);
    end
    exp_resp.push_back('{hit: 1'b1, data: 8'h3C});
    issue(1'b0, 8'h09, 8'h00);
    @(negedge clk);
    n_assert++;
    if (resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wmiss_reread_latency: resp_valid=%0b, expected 1", resp_valid);
    end
  endtask

  task automatic test_evict();
    // Index 1 holds dirty 0x09=0x3C: the write to 0x01 evicts it first.
    exp_mem.push_back('{we: 1'b1, addr: 8'h09, wdata: 8'h3C});
    exp_resp.push_back('{hit: 1'b0, data: 8'h11});
    issue(1'b1, 8'h01, 8'h11);
    wait_resp("evict_wmiss");
    n_assert++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL evict_wmiss_ready: got %0b in response cycle, expected 0", req_ready);
    end
    exp_mem.push_back('{we: 1'b1, addr: 8'h01, wdata: 8'h11});
    exp_mem.push_back('{we: 1'b0, addr: 8'h05, wdata: 8'h00});
    exp_resp.push_back('{hit: 1'b0, data: 8'hA5});
    issue(1'b0, 8'h05, 8'h00);
    wait_resp("evict_rmiss");
    n_assert++;
    if (mem_arr[8'h09] !== 8'h3C || mem_arr[8'h01] !== 8'h11) begin
      n_fail++;
      $display("FAIL evict_mem_contents: got [09]=%02h [01]=%02h, expected 3C 11", mem_arr[8'h09], mem_arr[8'h01]);
    end
  endtask

  task automatic test_evict_stall();
    exp_resp.push_back('{hit: 1'b0, data: 8'h22});
    issue(1'b1, 8'h02, 8'h22);
    wait_resp("stall_setup");
    mem_req_ready = 1'b0;
    exp_mem.push_back('{we: 1'b1, addr: 8'h02, wdata: 8'h22});
    exp_mem.push_back('{we: 1'b0, addr: 8'h06, wdata: 8'h00});
    exp_resp.push_back('{hit: 1'b0, data: 8'hA6});
    issue(1'b0, 8'h06, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_assert++;
      if ({mem_req_valid, mem_we, mem_addr, mem_wdata, req_ready, resp_valid} !== {1'b1, 1'b1, 8'h02, 8'h22, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL evict_stall[%0d]: got mv=%0b we=%0b addr=%02h wd=%02h rdy=%0b rv=%0b, expected 1 1 02 22 0 0", i, mem_req_valid, mem_we, mem_addr, mem_wdata, req_ready, resp_valid);
      end
    end
    @(posedge clk);
    #1;
    mem_req_ready = 1'b1;
    wait_resp("stall_done");
  endtask

  task automatic test_back_to_back();
    exp_resp.push_back('{hit: 1'b1, data: 8'h5A});
    exp_resp.push_back('{hit: 1'b1, data: 8'h5A});
    @(negedge clk);
    n_assert++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready0: got %0b, expected 1", req_ready);
    end
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 8'h06;
    req_wdata = 8'h5A;
    @(posedge clk);
    #1;
    req_we    = 1'b0;
    req_wdata = 8'h00;
    @(negedge clk);
    n_assert++;
    if ({resp_valid, req_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_first: got valid=%0b ready=%0b, expected 1 1", resp_valid, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_assert++;
    if (resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: resp_valid=%0b, expected 1", resp_valid);
    end
  endtask

  task automatic test_reset_mid_fill();
    int n = 0;
    exp_mem.push_back('{we: 1'b0, addr: 8'h0B, wdata: 8'h00});
    issue(1'b0, 8'h0B, 8'h00);
    while (!(mem_req_valid === 1'b1 && mem_we === 1'b0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_assert++;
    if (mem_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midfill_req: mem_req_valid=%0b, expected 1", mem_req_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_assert++;
      if ({resp_valid, mem_req_valid, req_ready} !== 3'b001) begin
        n_fail++;
        $display("FAIL midfill_abort[%0d]: got rv=%0b mv=%0b rdy=%0b, expected 0 0 1", i, resp_valid, mem_req_valid, req_ready);
      end
    end
    // Valid bits cleared: 0x05 misses again; dirty 0x06=0x5A was discarded.
    exp_mem.push_back('{we: 1'b0, addr: 8'h05, wdata: 8'h00});
    exp_resp.push_back('{hit: 1'b0, data: 8'hA5});
    issue(1'b0, 8'h05, 8'h00);
    wait_resp("midfill_reread");
    exp_mem.push_back('{we: 1'b0, addr: 8'h06, wdata: 8'h00});
    exp_resp.push_back('{hit: 1'b0, data: 8'hA6});
    issue(1'b0, 8'h06, 8'h00);
    wait_resp("midfill_discard");
  endtask

`ifdef CACHE_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_mem.push_back('{we: 1'b0, addr: 8'h10, wdata: 8'h00});
    exp_resp.push_back('{hit: 1'b0, data: 8'hB0});
    issue(1'b0, 8'h10, 8'h00);
    wait_resp("stats_m1");
    exp_resp.push_back('{hit: 1'b1, data: 8'hB0});
    issue(1'b0, 8'h10, 8'h00);
    exp_resp.push_back('{hit: 1'b1, data: 8'h77});
    issue(1'b1, 8'h10, 8'h77);
    exp_resp.push_back('{hit: 1'b1, data: 8'h77});
    issue(1'b0, 8'h10, 8'h00);
    exp_mem.push_back('{we: 1'b1, addr: 8'h10, wdata: 8'h77});
    exp_mem.push_back('{we: 1'b0, addr: 8'h14, wdata: 8'h00});
    exp_resp.push_back('{hit: 1'b0, data: 8'hB4});
    issue(1'b0, 8'h14, 8'h00);
    wait_resp("stats_m2");
    @(negedge clk);
    n_assert++;
    if (hit_cnt !== 16'd3 || miss_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL stats_counts: got hit=%0d miss=%0d, expected 3 2", hit_cnt, miss_cnt);
    end
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h14;
    for (int i = 0; i < 70000; i++) begin
      exp_resp.push_back('{hit: 1'b1, data: 8'hB4});
      @(posedge clk);
    end
    #1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++;
    if (hit_cnt !== 16'hFFFF || miss_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL stats_saturate: got hit=%04h miss=%0d, expected FFFF 2", hit_cnt, miss_cnt);
    end
  endtask
`endif

  task automatic test_drain();
    repeat (4) @(negedge clk);
    n_assert++;
    if (exp_resp.size() != 0 || exp_mem.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d responses and %0d memory requests outstanding, expected 0 0", exp_resp.size(), exp_mem.size());
    end
  endtask

  initial begin
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_we        = 1'b0;
    req_addr      = 8'h00;
    req_wdata     = 8'h00;
    mem_req_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 8'(i) ^ 8'hA0;
    end
    test_reset();
    test_read_miss();
    test_write_clean_miss();
    test_evict();
    test_evict_stall();
    test_back_to_back();
    test_reset_mid_fill();
`ifdef CACHE_STATS_EN
    test_stats();
`endif
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
